key_request_capture_4ch: RTL and testbench

Upstream stage for the 4-line encoder. It synchronizes and debounces four raw request lines (push-buttons or async strobes), selects one request by fixed priority, and presents it as a clean one-hot pattern on d0..d3 with a valid/ack handshake. It holds that pattern until acknowledged. It then waits for all lines to release before accepting the next request, so the downstream encoder only ever sees all-zero or exactly one line high.

---
 rtl/key_request_capture_4ch.sv | 117 +++++++++++
 tb/tb_key_request_capture_4ch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/key_request_capture_4ch.sv
// Four-line request front end: 2-flop synchronizer, per-line debouncer, priority capture
// held as a registered one-hot pattern with a valid/ack handshake and sticky missed flag.
module key_request_capture_4ch #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic r0,
    input  logic r1,
    input  logic r2,
    input  logic r3,
    input  logic ack,
    output logic d0,
    output logic d1,
    output logic d2,
    output logic d3,
    output logic valid,
    output logic missed
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, WAIT_RELEASE} state_t;

    state_t          state, state_nxt;
    logic [3:0]      raw, s1, s, db, db_nxt;
    logic [3:0]      d, d_nxt;
    logic            valid_nxt, missed_nxt;
    logic [CW-1:0]   cnt [4];
    logic [CW-1:0]   cnt_nxt [4];

    assign raw = {r3, r2, r1, r0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= '0;
            s      <= '0;
            db     <= '0;
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
            state  <= IDLE;
            d      <= '0;
            valid  <= 1'b0;
            missed <= 1'b0;
        end else begin
            s1     <= raw;
            s      <= s1;
            db     <= db_nxt;
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= cnt_nxt[i];
            state  <= state_nxt;
            d      <= d_nxt;
            valid  <= valid_nxt;
            missed <= missed_nxt;
        end
    end

    always_comb begin
        db_nxt = db;
        for (int unsigned i = 0; i < 4; i++) begin
            cnt_nxt[i] = '0;
            if (s[i] != db[i]) begin
                if (cnt[i] == CNT_MAX) db_nxt[i] = s[i];
                else                   cnt_nxt[i] = cnt[i] + 1'b1;
            end
        end
    end

    // Rise detection uses db_nxt so missed asserts on the same edge the other line debounces.
    always_comb begin
        state_nxt  = state;
        d_nxt      = d;
        valid_nxt  = valid;
        missed_nxt = missed;
        case (state)
            IDLE: begin
                d_nxt      = '0;
                valid_nxt  = 1'b0;
                missed_nxt = 1'b0;
                if (|db) begin
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                    if (db[3])      d_nxt = 4'b1000;
                    else if (db[2]) d_nxt = 4'b0100;
                    else if (db[1]) d_nxt = 4'b0010;
                    else            d_nxt = 4'b0001;
                end
            end
            HOLD: begin
                if (ack) begin
                    d_nxt      = '0;
                    valid_nxt  = 1'b0;
                    missed_nxt = 1'b0;
                    state_nxt  = WAIT_RELEASE;
                end else if (|(db_nxt & ~db & ~d)) begin
                    missed_nxt = 1'b1;
                end
            end
            WAIT_RELEASE: begin
                d_nxt      = '0;
                valid_nxt  = 1'b0;
                missed_nxt = 1'b0;
                if (db == 4'b0000) state_nxt = IDLE;
            end
            default: begin
                d_nxt      = '0;
                valid_nxt  = 1'b0;
                missed_nxt = 1'b0;
                state_nxt  = IDLE;
            end
        endcase
    end

    assign d0 = d[0];
    assign d1 = d[1];
    assign d2 = d[2];
    assign d3 = d[3];

endmodule

// File: tb/tb_key_request_capture_4ch.sv
// Directed + randomized bench for key_request_capture_4ch against a window-based
// debounce model and a request-level handshake model.
module tb_key_request_capture_4ch;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic r0 = 1'b0, r1 = 1'b0, r2 = 1'b0, r3 = 1'b0;
    logic ack = 1'b0;
    logic d0, d1, d2, d3, valid, missed;

    int checks = 0;
    int failures = 0;

    key_request_capture_4ch #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .ack(ack),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .valid(valid), .missed(missed)
    );

    always #5 clk = ~clk;

    // Reference: raw sample history; a line's debounced level flips once the
    // last D synchronized samples (raw delayed two edges) all disagree with it.
    logic [3:0] hist [$];
    logic [3:0] m_db;
    logic [3:0] m_d;
    logic       m_valid, m_missed, m_wait;

    function automatic logic [5:0] outs();
        return {missed, valid, d3, d2, d1, d0};
    endfunction

    function automatic logic [5:0] model_outs();
        return {m_missed, m_valid, m_d};
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_front(4'b0000);
        m_db = '0; m_d = '0; m_valid = 1'b0; m_missed = 1'b0; m_wait = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] raw, input logic a);
        logic [3:0] ndb;
        logic [3:0] smp;
        logic       flip;
        hist.push_front(raw);
        if (hist.size() > D + 2) void'(hist.pop_back());
        for (int i = 0; i < 4; i++) begin
            flip = 1'b1;
            for (int j = 0; j < D; j++) begin
                smp = hist[j + 2];
                if (smp[i] == m_db[i]) flip = 1'b0;
            end
            ndb[i] = m_db[i] ^ flip;
        end
        if (m_valid) begin
            if (a) begin
                m_valid = 1'b0; m_d = '0; m_missed = 1'b0; m_wait = 1'b1;
            end else if (|(ndb & ~m_db & ~m_d)) begin
                m_missed = 1'b1;
            end
        end else if (m_wait) begin
            if (m_db == 4'b0000) m_wait = 1'b0;
        end else if (m_db != 4'b0000) begin
            m_valid = 1'b1;
            m_d = '0;
            for (int i = 3; i >= 0; i--) begin
                if (m_db[i] && m_d == 4'b0000) m_d[i] = 1'b1;
            end
        end
        m_db = ndb;
    endtask

    task automatic step();
        logic [3:0] raw;
        logic       a;
        raw = {r3, r2, r1, r0};
        a   = ack;
        @(posedge clk);
        model_edge(raw, a);
        #1;
        check("outs", outs(), model_outs());
        check("db", {2'b00, dut.db}, {2'b00, m_db});
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_raw(input logic [3:0] v);
        {r3, r2, r1, r0} = v;
    endtask

    initial begin
        model_reset();
        #2;
        check("reset_outs", outs(), 6'b000000);
        @(posedge clk);
        #1 rst = 1'b0;

        // capture d2, then async reset mid-HOLD
        set_raw(4'b0100);
        steps(8);
        check("hold_d2", outs(), 6'b010100);
        #3 rst = 1'b1;
        #1;
        check("async_reset", outs(), 6'b000000);
        model_reset();
        set_raw(4'b0000);
        @(posedge clk);
        #1 rst = 1'b0;
        check("reset_db", {2'b00, dut.db}, 6'b000000);

        // r1 pulse of 8 cycles: valid exactly at edge 7
        set_raw(4'b0010);
        steps(6);
        check("r1_edge6", outs(), 6'b000000);
        step();
        check("r1_edge7", outs(), 6'b010010);
        step();
        set_raw(4'b0000);
        ack = 1'b1; step(); ack = 1'b0;
        steps(8);

        // glitch shorter than D
        set_raw(4'b0001);
        steps(3);
        set_raw(4'b0000);
        steps(10);
        check("glitch", outs(), 6'b000000);

        // simultaneous r1/r3 rise
        set_raw(4'b1010);
        steps(7);
        check("priority", outs(), 6'b011000);
        ack = 1'b1; step(); ack = 1'b0;
        set_raw(4'b0000);
        steps(8);

        // handshake on d0 with ack at edge 12, line kept high
        set_raw(4'b0001);
        steps(11);
        check("hs_hold", outs(), 6'b010001);
        ack = 1'b1; step(); ack = 1'b0;
        check("hs_ack", outs(), 6'b000000);
        steps(10);
        check("hs_no_retrig", outs(), 6'b000000);
        set_raw(4'b0000);
        steps(7);
        set_raw(4'b0001);
        steps(7);
        check("hs_recapture", outs(), 6'b010001);
        ack = 1'b1; step(); ack = 1'b0;
        set_raw(4'b0000);
        steps(8);

        // missed: hold d1, r2 debounces during HOLD
        set_raw(4'b0010);
        steps(7);
        set_raw(4'b0110);
        steps(5);
        check("missed_pre", outs(), 6'b010010);
        step();
        check("missed_set", outs(), 6'b110010);
        ack = 1'b1; step(); ack = 1'b0;
        check("missed_clr", outs(), 6'b000000);
        set_raw(4'b0000);
        steps(8);
        ack = 1'b1; steps(3); ack = 1'b0;
        check("ack_idle", outs(), 6'b000000);

        // stuck r3 across ack
        set_raw(4'b1000);
        steps(7);
        ack = 1'b1; step(); ack = 1'b0;
        steps(20);
        check("stuck", outs(), 6'b000000);
        set_raw(4'b0000);
        steps(8);

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 7) == 0) r0 = ~r0;
            if ($urandom_range(0, 7) == 0) r1 = ~r1;
            if ($urandom_range(0, 7) == 0) r2 = ~r2;
            if ($urandom_range(0, 7) == 0) r3 = ~r3;
            ack = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
